// File: rtl/muldiv_pkg.sv
// Shared opcode and state definitions for the HI/LO multiply/divide engine.
package muldiv_pkg;

    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MULT);
    endfunction

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per step, MSB first.
module div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Borrow out of diff[WIDTH] means the trial subtraction must be discarded.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing the HI/LO pair with a start/busy/done handshake.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MCW = $clog2(MUL_LAT + 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sgn_q;
    logic               setup_q;
    logic [MCW-1:0]     mcnt_q;
    logic [2*WIDTH-1:0] prod_pipe [MUL_LAT];

    logic               accept;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_load;
    logic               div_step;
    logic               div_last;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign accept = start && !cancel && (state_q == StIdle) && (is_mul_op(op) || is_div_op(op));

    // The product is formed from the live operands on the accept edge, then only delayed.
    always_comb begin
        if (op == OP_MULT) begin
            ext_a = {{WIDTH{src_a[WIDTH-1]}}, src_a};
            ext_b = {{WIDTH{src_b[WIDTH-1]}}, src_b};
        end else begin
            ext_a = {{WIDTH{1'b0}}, src_a};
            ext_b = {{WIDTH{1'b0}}, src_b};
        end
        product = ext_a * ext_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                prod_pipe[k] <= '0;
            end
        end else begin
            if (accept && is_mul_op(op)) begin
                prod_pipe[0] <= product;
            end
            for (int k = 1; k < MUL_LAT; k++) begin
                prod_pipe[k] <= prod_pipe[k-1];
            end
        end
    end

    always_comb begin
        mag_a    = (sgn_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
        mag_b    = (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
        div_load = (state_q == StDiv) && setup_q;
        div_step = (state_q == StDiv) && !setup_q;
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .q        (div_q),
        .r        (div_r),
        .last     (div_last)
    );

    // Quotient negates on differing signs; remainder follows the dividend; zero divisor is special.
    always_comb begin
        if (b_q == '0) begin
            lo_fix = '1;
            hi_fix = a_q;
        end else begin
            lo_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~div_q + 1'b1) : div_q;
            hi_fix = (sgn_q && a_q[WIDTH-1]) ? (~div_r + 1'b1) : div_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            setup_q <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= src_a;
                        b_q     <= src_b;
                        sgn_q   <= is_signed_op(op);
                        mcnt_q  <= '0;
                        setup_q <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= is_mul_op(op) ? StMul : StDiv;
                    end
                end
                StMul: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (mcnt_q == MCW'(MUL_LAT - 1)) begin
                        {hi, lo} <= prod_pipe[MUL_LAT-1];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        mcnt_q <= mcnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        setup_q <= 1'b0;
                        if (!setup_q && div_last) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        hi      <= hi_fix;
                        lo      <= lo_fix;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomised and directed bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_bad    = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(
        .WIDTH   (32),
        .MUL_LAT (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = '0;
        mhi = '0;
        mlo = '0;
        case (o)
            OP_MULT:  begin p = sa * sb; {mhi, mlo} = p; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; end
            OP_DIVU: begin
                if (b == 0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
                else begin mlo = a / b; mhi = a % b; end
            end
            default: begin
                if (b == 0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
                else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    mlo = 32'(sq);
                    mhi = 32'(sr);
                end
            end
        endcase
    endfunction

    // Launches one op; optional cycle indices inject a cancel, a stray start or a reset.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int restart_at, input int reset_at);
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat_exp;
        int          busy_cnt;
        bit          got_done;
        bit          aborted;
        model(o, a, b, ehi, elo);
        lat_exp  = is_mul_op(o) ? 3 : 34;
        busy_cnt = 0;
        got_done = 0;
        aborted  = (cancel_at > 0) || (reset_at > 0);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            start = 1'b0; cancel = 1'b0; reset = 1'b0;
            op = 3'($urandom); src_a = $urandom; src_b = $urandom;
            if (busy) busy_cnt++;
            if (done) begin
                got_done = 1;
                if (!aborted) begin
                    check_eq("latency", 64'(i - 1), 64'(lat_exp));
                    check_eq("busy_cycles", 64'(busy_cnt), 64'(lat_exp));
                    check_eq("hi", 64'(hi), 64'(ehi));
                    check_eq("lo", 64'(lo), 64'(elo));
                    last_hi = ehi;
                    last_lo = elo;
                    break;
                end
            end
            if (cancel_at > 0 && i == cancel_at) cancel = 1'b1;
            if (cancel_at > 0 && i == cancel_at + 1) check_eq("cancel_busy", 64'(busy), 64'(0));
            if (restart_at > 0 && i == restart_at) begin start = 1'b1; op = OP_MULTU; end
            if (reset_at > 0 && i == reset_at) reset = 1'b1;
            if (reset_at > 0 && i == reset_at + 1) begin
                check_eq("reset_outputs", {30'd0, busy, done, hi}, 64'(0));
                check_eq("reset_lo", 64'(lo), 64'(0));
                last_hi = '0;
                last_lo = '0;
            end
        end
        if (aborted) begin
            check_eq("abort_no_done", 64'(got_done), 64'(0));
            check_eq("abort_hilo", {hi, lo}, {last_hi, last_lo});
        end else begin
            check_eq("done_seen", 64'(got_done), 64'(1));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {30'd0, busy, done, hi}, 64'(0));
        check_eq("reset_lo", 64'(lo), 64'(0));
        reset = 1'b0;

        run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
        run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 0, 0, 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(OP_DIV,   32'd100, 32'd3, 0, 5, 0);

        // Start during the DONE cycle must be dropped.
        start = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_in_done", 64'(busy), 64'(0));

        run_op(OP_DIV, 32'd100, 32'd3, 10, 0, 0);

        // Cancel wins over a simultaneous start in IDLE.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_DIV; src_a = 32'd9; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_eq("cancel_beats_start", 64'(busy), 64'(0));

        run_op(OP_DIV, 32'd100, 32'd3, 0, 0, 0);
        run_op(OP_DIV, 32'd100, 32'd3, 0, 0, 20);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd4, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            run_op(3'($urandom_range(1, 4)), pick_operand(), pick_operand(), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
